// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit and its decoder.
package mdu_pkg;

  localparam int MDU_WIDTH   = 32;
  // Cycles from the start edge to the edge that commits HI/LO.
  localparam int MDU_LATENCY = 33;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic    valid;
    mdu_op_t op;
  } mdu_dec_t;

  // Map a MIPS SPECIAL funct field to an MDU operation; valid=0 for non-MDU functs.
  function automatic mdu_dec_t mdu_op_from_funct(input logic [5:0] funct);
    mdu_dec_t d;
    d.valid = 1'b1;
    d.op    = MULT;
    case (funct)
      6'h18:   d.op = MULT;
      6'h19:   d.op = MULTU;
      6'h1A:   d.op = DIV;
      6'h1B:   d.op = DIVU;
      6'h11:   d.op = MTHI;
      6'h13:   d.op = MTLO;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the issue stage and the MDU.
// Handshake: start is a one-cycle request that the MDU samples only while
// busy=0 (flush wins over start). Mul/div raise busy for the whole operation
// and pulse done for one cycle after HI/LO commit; MTHI/MTLO complete at the
// sampling edge without busy or done. Holding off issue while busy=1 is the
// caller's responsibility; a start seen while busy is dropped.
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_t     op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, op_a, op_b, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, op_a, op_b, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on a
// 64-bit accumulator. Operands arrive as magnitudes; signs live in mdu.
module mdu_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] load_acc_lo, // multiplier (mul) or dividend (div)
  input  logic [31:0] load_opnd,   // multiplicand (mul) or divisor (div)
  output logic [63:0] acc
);

  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] opnd_q;
  logic [32:0] mul_sum;
  logic [32:0] shifted_rem;
  logic [32:0] trial;

  // Next accumulator value for one multiply or divide iteration.
  always_comb begin
    mul_sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    shifted_rem = acc_q[63:31];
    trial       = shifted_rem - {1'b0, opnd_q};
    acc_d       = acc_q;
    if (div_mode) begin
      // A borrow means the divisor does not fit: keep the shifted remainder.
      if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
      else            acc_d = {shifted_rem[31:0], acc_q[30:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
    end
  end

  // Working registers: loaded on accept, advanced once per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load) begin
      acc_q  <= {32'd0, load_acc_lo};
      opnd_q <= load_opnd;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO: FSM, sign handling, commit.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_if.slave       bus,
  output mdu_state_t dbg_state
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  param_ok: assert property (@(posedge clk) (WIDTH == 32) && (ITERS == WIDTH));

  mdu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        accept, step, commit, wr_hi, wr_lo;
  logic        is_muldiv, is_div, is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_q, neg_res_q, neg_rem_q, dz_q;
  logic [31:0] raw_a_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic [63:0] acc;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  // Operand decode and magnitudes for the signed forms.
  always_comb begin
    is_muldiv = bus.op inside {MULT, MULTU, DIV, DIVU};
    is_div    = bus.op inside {DIV, DIVU};
    is_signed = bus.op inside {MULT, DIV};
    a_neg     = is_signed & bus.op_a[31];
    b_neg     = is_signed & bus.op_b[31];
    a_mag     = a_neg ? (~bus.op_a + 32'd1) : bus.op_a;
    b_mag     = b_neg ? (~bus.op_b + 32'd1) : bus.op_b;
  end

  // Next state and one-cycle controls; flush beats start and aborts RUN/FIX.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_muldiv) begin
            accept  = 1'b1;
            state_d = RUN;
          end
          wr_hi = (bus.op == MTHI);
          wr_lo = (bus.op == MTLO);
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        commit  = !bus.flush;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Iteration counter and per-operation flags captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      raw_a_q   <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      div_q     <= is_div;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= is_div && (bus.op_b == 32'd0);
      raw_a_q   <= bus.op_a;
    end else if (step && cnt_q != LAST) begin
      cnt_q     <= cnt_q + CW'(1);
    end
  end

  mdu_iter_core u_core (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .step        (step),
    .div_mode    (accept ? is_div : div_q),
    .load_acc_lo (is_div ? a_mag : b_mag),
    .load_opnd   (is_div ? b_mag : a_mag),
    .acc         (acc)
  );

  // Sign correction of the magnitude result.
  always_comb begin
    prod = neg_res_q ? (~acc + 64'd1) : acc;
    quo  = neg_res_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = neg_rem_q ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // HI/LO: mul/div commit in FIX, MTHI/MTLO write directly from IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (!div_q) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end else if (dz_q) begin
        hi_q <= raw_a_q;
        lo_q <= 32'hFFFF_FFFF;
      end else begin
        hi_q <= rem;
        lo_q <= quo;
      end
    end else if (wr_hi) begin
      hi_q <= bus.op_a;
    end else if (wr_lo) begin
      lo_q <= bus.op_a;
    end
  end

  // Done pulses for the cycle following a commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= commit;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign dbg_state = state_q;

endmodule
